apb_reg_slave: RTL and testbench

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_reg_bank.sv | 49 ++++
 rtl/apb_reg_slave.sv | 147 ++++++++++++++
 tb/tb_apb_reg_slave.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register slave.
// Holds the transfer FSM state encoding and the register-index width helper.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_state_e;

  // Number of index bits needed to address num_regs registers (at least 1).
  function automatic int reg_idx_w(input int num_regs);
    int w;
    w = $clog2(num_regs);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage with byte-strobe writes and a read mux that substitutes
// the external ro_in value for registers marked read-only.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int                   DATA_W   = APB_DATA_W,
  parameter int                   NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK  = {NUM_REGS{1'b0}},
  parameter int                   IDX_W    = reg_idx_w(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [IDX_W-1:0]             idx,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          strb,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
  output logic [DATA_W-1:0]            rdata,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out
);

  logic [NUM_REGS*DATA_W-1:0] regs_r;

  // Storage update: only strobed bytes of writable registers change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_r <= {NUM_REGS*DATA_W{1'b0}};
    end else if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (strb[b] && !RO_MASK[idx]) begin
          regs_r[int'(idx)*DATA_W + b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read mux: read-only registers reflect ro_in, others the stored value.
  always_comb begin
    rdata = {DATA_W{1'b0}};
    if (RO_MASK[idx]) begin
      rdata = ro_in[int'(idx)*DATA_W +: DATA_W];
    end else begin
      rdata = regs_r[int'(idx)*DATA_W +: DATA_W];
    end
  end

  assign reg_out = regs_r;

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave: setup/wait/ready transfer FSM, address decode and
// error generation around an apb_reg_bank storage block.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int                   ADDR_W      = APB_ADDR_W,
  parameter int                   DATA_W      = APB_DATA_W,
  parameter int                   NUM_REGS    = 16,
  parameter int                   WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = {NUM_REGS{1'b0}}
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic [DATA_W-1:0]            PWDATA,
  input  logic [DATA_W/8-1:0]          PSTRB,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out
);

  localparam int IDX_W = reg_idx_w(NUM_REGS);

  apb_state_e          state_r;
  logic [3:0]          cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                wr_r;

  logic [ADDR_W-1:0]   dec_addr_s;
  logic                dec_wr_s;
  logic [IDX_W-1:0]    dec_idx_s;
  logic                addr_ok_s;
  logic                err_s;
  logic [DATA_W-1:0]   bank_rdata_s;
  logic [DATA_W-1:0]   rd_load_s;
  logic                we_s;

  // Decode uses the live bus in IDLE (zero-wait setup) and the captured
  // address/direction for the rest of the transfer.
  always_comb begin
    dec_addr_s = addr_r;
    dec_wr_s   = wr_r;
    if (state_r == ST_IDLE) begin
      dec_addr_s = PADDR;
      dec_wr_s   = PWRITE;
    end else begin
      dec_addr_s = addr_r;
      dec_wr_s   = wr_r;
    end
  end

  assign dec_idx_s = dec_addr_s[IDX_W+1:2];
  assign addr_ok_s = (dec_addr_s[1:0] == 2'b00) &&
                     ((dec_addr_s >> (IDX_W + 2)) == {ADDR_W{1'b0}});
  assign err_s     = !addr_ok_s || (dec_wr_s && RO_MASK[dec_idx_s]);
  assign rd_load_s = (!dec_wr_s && !err_s) ? bank_rdata_s : {DATA_W{1'b0}};

  // Commit happens on the completion edge; an errored write never reaches the bank.
  assign we_s = (state_r == ST_READY) && PSEL && PENABLE && wr_r && !PSLVERR;

  apb_reg_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RO_MASK  (RO_MASK),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .we      (we_s),
    .idx     (dec_idx_s),
    .wdata   (PWDATA),
    .strb    (PSTRB),
    .ro_in   (ro_in),
    .rdata   (bank_rdata_s),
    .reg_out (reg_out)
  );

  // Transfer FSM with registered PREADY/PSLVERR/PRDATA.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= {ADDR_W{1'b0}};
      wr_r    <= 1'b0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= {DATA_W{1'b0}};
          if (PSEL && !PENABLE) begin
            addr_r <= PADDR;
            wr_r   <= PWRITE;
            if (WAIT_CYCLES == 0) begin
              state_r <= ST_READY;
              PREADY  <= 1'b1;
              PSLVERR <= err_s;
              PRDATA  <= rd_load_s;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
              state_r <= ST_READY;
              PREADY  <= 1'b1;
              PSLVERR <= err_s;
              PRDATA  <= rd_load_s;
            end
          end
        end
        ST_READY: begin
          // Completion (PENABLE) and abort (PSEL low) both end the transfer.
          if (!PSEL || PENABLE) begin
            state_r <= ST_IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= {DATA_W{1'b0}};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: a 2-wait-state instance and a
// zero-wait instance share the APB bus, each with its own PSEL.
module tb_apb_reg_slave;

  logic          clk = 1'b0;
  logic          rstn;
  logic          psel0, psel1, penable, pwrite;
  logic [31:0]   paddr, pwdata;
  logic [3:0]    pstrb;
  logic [511:0]  ro_in;
  logic [31:0]   prdata0, prdata1;
  logic          pready0, pready1, pslverr0, pslverr1;
  logic [511:0]  reg_out0, reg_out1;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  apb_reg_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(2),
                  .RO_MASK(16'h0001)) u0 (
    .PCLK(clk), .PRESETn(rstn), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0),
    .PREADY(pready0), .PSLVERR(pslverr0), .ro_in(ro_in), .reg_out(reg_out0));

  apb_reg_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(0),
                  .RO_MASK(16'h0001)) u1 (
    .PCLK(clk), .PRESETn(rstn), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata1),
    .PREADY(pready1), .PSLVERR(pslverr1), .ro_in(ro_in), .reg_out(reg_out1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops the expected response whenever a selected slave completes.
  always @(negedge clk) begin
    if (penable && ((psel0 && pready0) || (psel1 && pready1))) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_prdata",  psel1 ? prdata1 : prdata0, e.rdata);
        chk("sb_pslverr", {31'd0, psel1 ? pslverr1 : pslverr0}, {31'd0, e.err});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One APB transfer, entered just after a rising edge.
  task automatic xfer(input bit sel, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] exp_rd, input bit exp_err,
                      input int exp_lat, input bit rst_at_ready);
    int lat;
    exp_q.push_back('{exp_rd, exp_err});
    paddr = addr; pwrite = wr; pwdata = data; pstrb = strb; penable = 1'b0;
    if (sel) psel1 = 1'b1; else psel0 = 1'b1;
    @(negedge clk);
    chk("setup_pready", {31'd0, sel ? pready1 : pready0}, 32'd0);
    chk("setup_prdata", sel ? prdata1 : prdata0, 32'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (sel ? pready1 : pready0) lat = i;
    end
    chk("access_latency", lat, exp_lat);
    if (lat == 0) void'(exp_q.pop_front());
    if (rst_at_ready) rstn = 1'b0;
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rstn = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0; pstrb = 4'd0;
    ro_in = '0;
    ro_in[31:0]    = 32'h5A5A0001;
    ro_in[159:128] = 32'hFFFF0000;
    idle(3);
    @(negedge clk);
    chk("rst_pready",  {31'd0, pready0},  32'd0);
    chk("rst_pslverr", {31'd0, pslverr0}, 32'd0);
    chk("rst_prdata",  prdata0, 32'd0);
    chk("rst_reg_out", {31'd0, |reg_out0}, 32'd0);
    rstn = 1'b1;
    idle(1);

    // Full write then read-back, three access cycles each.
    xfer(0, 1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0, 0, 3, 0);
    chk("reg_out1_after_write", reg_out0[63:32], 32'hDEADBEEF);
    xfer(0, 0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, 0, 3, 0);

    // Byte strobes merge into existing contents.
    xfer(0, 1, 32'h08, 32'h11223344, 4'hF,    32'h0, 0, 3, 0);
    xfer(0, 1, 32'h08, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 3, 0);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 32'h11BB33DD, 0, 3, 0);
    xfer(0, 1, 32'h08, 32'hFFFFFFFF, 4'h0,    32'h0, 0, 3, 0);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 32'h11BB33DD, 0, 3, 0);

    // Error cases: out of range, misaligned, read-only write.
    xfer(0, 0, 32'h40, 32'h0, 4'h0, 32'h0, 1, 3, 0);
    xfer(0, 0, 32'h06, 32'h0, 4'h0, 32'h0, 1, 3, 0);
    xfer(0, 1, 32'h00, 32'h12345678, 4'hF, 32'h0, 1, 3, 0);
    xfer(0, 1, 32'h44, 32'h12345678, 4'hF, 32'h0, 1, 3, 0);
    xfer(0, 0, 32'h00, 32'h0, 4'h0, 32'h5A5A0001, 0, 3, 0);
    chk("ro_reg_not_stored", reg_out0[31:0], 32'h0);

    // Abort in WAIT: PSEL drops after the first access cycle.
    paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h99999999; pstrb = 4'hF;
    psel0 = 1'b1; penable = 1'b0;
    idle(1);
    penable = 1'b1;
    idle(1);
    psel0 = 1'b0; penable = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (pready0) seen++;
    end
    chk("abort_no_ready", seen, 0);
    chk("abort_reg3", reg_out0[127:96], 32'h0);
    idle(1);
    xfer(0, 0, 32'h0C, 32'h0, 4'h0, 32'h0, 0, 3, 0);

    // Reset in READY of a write discards it and clears the bank.
    xfer(0, 1, 32'h04, 32'h12345678, 4'hF, 32'h0, 0, 3, 1);
    @(negedge clk);
    chk("rst_ready_pready", {31'd0, pready0}, 32'd0);
    chk("rst_ready_reg1",   reg_out0[63:32], 32'h0);
    chk("rst_ready_reg2",   reg_out0[95:64], 32'h0);
    idle(1);
    rstn = 1'b1;
    idle(1);
    xfer(0, 0, 32'h04, 32'h0, 4'h0, 32'h0, 0, 3, 0);

    // Zero-wait instance, back-to-back transfers.
    xfer(1, 1, 32'h10, 32'hCAFEF00D, 4'hF, 32'h0, 0, 1, 0);
    xfer(1, 0, 32'h10, 32'h0, 4'h0, 32'hCAFEF00D, 0, 1, 0);
    xfer(1, 1, 32'h3C, 32'hABCDEF01, 4'b1000, 32'h0, 0, 1, 0);
    xfer(1, 0, 32'h3C, 32'h0, 4'h0, 32'hAB000000, 0, 1, 0);
    xfer(1, 0, 32'h41, 32'h0, 4'h0, 32'h0, 1, 1, 0);
    chk("zw_reg4", reg_out1[159:128], 32'hCAFEF00D);

    idle(2);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
